// File: rtl/vga_reg_pkg.sv
// Shared definitions for the display register bus: widths, register map
// and the state type of the vsync-gated register writer.
package vga_reg_pkg;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 32;

    localparam logic [ADDR_W-1:0] DINO_X     = 9'd0;
    localparam logic [ADDR_W-1:0] DINO_Y     = 9'd1;
    localparam logic [ADDR_W-1:0] CACTUS_X   = 9'd2;
    localparam logic [ADDR_W-1:0] CACTUS_Y   = 9'd3;
    localparam logic [ADDR_W-1:0] BIRD_X     = 9'd4;
    localparam logic [ADDR_W-1:0] BIRD_Y     = 9'd5;
    localparam logic [ADDR_W-1:0] CLOUD_X    = 9'd6;
    localparam logic [ADDR_W-1:0] CLOUD_Y    = 9'd7;
    localparam logic [ADDR_W-1:0] GODZILLA_X = 9'd8;
    localparam logic [ADDR_W-1:0] GODZILLA_Y = 9'd9;
    localparam logic [ADDR_W-1:0] SCORE      = 9'd10;
    localparam logic [ADDR_W-1:0] SCORE_X    = 9'd11;
    localparam logic [ADDR_W-1:0] SCORE_Y    = 9'd12;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_WAIT_END = 2'd2
    } wr_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; dout always shows the head entry.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 41
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr_reg];
    assign count   = count_reg;

    // Storage carries no reset so it can map onto RAM; pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/vga_reg_writer.sv
// Queues display register updates and replays them onto the register bus
// only while vertical sync is low, at most MAX_BURST writes per window.
module vga_reg_writer
    import vga_reg_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int MAX_BURST = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [DATA_W-1:0]       req_data,
    input  logic                    vga_vs_n,
    output logic                    chipselect,
    output logic                    write,
    output logic [ADDR_W-1:0]       address,
    output logic [DATA_W-1:0]       writedata,
    output logic [$clog2(DEPTH):0]  pending,
    output logic                    frame_done
);
    localparam int BW = $clog2(MAX_BURST + 1);

    wr_state_t              state_reg, state_next;
    logic                   vs_q_reg;
    logic [BW-1:0]          burst_cnt_reg, burst_cnt_next;
    logic                   vs_start, vs_end, entering, burst_ok, pop, drain_exit;
    logic                   fifo_full, fifo_empty;
    logic [ADDR_W+DATA_W-1:0] fifo_dout;
    logic [ADDR_W-1:0]      head_addr;
    logic [DATA_W-1:0]      head_data;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_W + DATA_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (req_valid && req_ready),
        .pop   (pop),
        .din   ({req_addr, req_data}),
        .dout  (fifo_dout),
        .count (pending),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign req_ready              = !fifo_full;
    assign {head_addr, head_data} = fifo_dout;

    // The vs_start edge itself already pops, so the first write lands one cycle later.
    always_comb begin
        vs_start       = vs_q_reg && !vga_vs_n;
        vs_end         = !vs_q_reg && vga_vs_n;
        entering       = (state_reg == ST_IDLE) && vs_start;
        burst_ok       = entering || (burst_cnt_reg < BW'(MAX_BURST));
        pop            = (entering || (state_reg == ST_DRAIN)) && !fifo_empty
                         && burst_ok && !vga_vs_n;
        state_next     = state_reg;
        burst_cnt_next = burst_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (vs_start) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (vs_end) begin
                    state_next = ST_IDLE;
                end else if (!vga_vs_n &&
                             (fifo_empty || burst_cnt_reg == BW'(MAX_BURST))) begin
                    state_next = ST_WAIT_END;
                end
            end
            ST_WAIT_END: begin
                if (vs_end) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        if (entering) begin
            burst_cnt_next = BW'(pop);
        end else if (pop) begin
            burst_cnt_next = burst_cnt_reg + 1'b1;
        end
        drain_exit = (state_reg == ST_DRAIN) && (state_next != ST_DRAIN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            vs_q_reg      <= 1'b1;
            burst_cnt_reg <= '0;
            chipselect    <= 1'b0;
            write         <= 1'b0;
            address       <= '0;
            writedata     <= '0;
            frame_done    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            vs_q_reg      <= vga_vs_n;
            burst_cnt_reg <= burst_cnt_next;
            chipselect    <= pop;
            write         <= pop;
            frame_done    <= drain_exit;
            if (pop) begin
                address   <= head_addr;
                writedata <= head_data;
            end
        end
    end

endmodule

// File: tb/tb_vga_reg_writer.sv
// Randomized and directed bench for vga_reg_writer against a queue-based
// model of vsync-window draining.
module tb_vga_reg_writer;
    import vga_reg_pkg::*;

    localparam int DEPTH     = 16;
    localparam int MAX_BURST = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [8:0]  req_addr = '0;
    logic [31:0] req_data = '0;
    logic        vga_vs_n = 1'b1;
    logic        chipselect, write, frame_done;
    logic [8:0]  address;
    logic [31:0] writedata;
    logic [$clog2(DEPTH):0] pending;

    vga_reg_writer #(.DEPTH(DEPTH), .MAX_BURST(MAX_BURST)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .vga_vs_n   (vga_vs_n),
        .chipselect (chipselect),
        .write      (write),
        .address    (address),
        .writedata  (writedata),
        .pending    (pending),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model: a queue of entries plus "inside a window / window finished" flags.
    logic [40:0] mq[$];
    bit          m_prev_vs = 1'b1;
    bit          m_in_win = 1'b0;
    bit          m_stopped = 1'b0;
    int          m_nwr = 0;
    bit          e_wr = 1'b0;
    bit          e_fd = 1'b0;
    logic [8:0]  e_addr = '0;
    logic [31:0] e_data = '0;

    int          wr_count = 0;
    int          fd_count = 0;
    logic [8:0]  addr_log[$];
    bit          cmp_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_step();
        bit fall, rise, starting, do_pop, fd, push_ok;
        fall     = m_prev_vs && !vga_vs_n;
        rise     = !m_prev_vs && vga_vs_n;
        starting = fall && !m_in_win;
        if (starting) begin
            m_in_win  = 1'b1;
            m_stopped = 1'b0;
            m_nwr     = 0;
        end
        do_pop  = m_in_win && !m_stopped && !vga_vs_n && mq.size() > 0 && m_nwr < MAX_BURST;
        fd      = m_in_win && !m_stopped && !starting &&
                  (rise || (!vga_vs_n && (mq.size() == 0 || m_nwr == MAX_BURST)));
        push_ok = req_valid && mq.size() < DEPTH;
        e_wr = do_pop;
        e_fd = fd;
        if (do_pop) begin
            {e_addr, e_data} = mq.pop_front();
            m_nwr++;
        end
        if (push_ok) mq.push_back({req_addr, req_data});
        if (fd) m_stopped = 1'b1;
        if (rise) m_in_win = 1'b0;
        m_prev_vs = vga_vs_n;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            m_prev_vs = 1'b1;
            m_in_win  = 1'b0;
            m_stopped = 1'b0;
            m_nwr     = 0;
            e_wr      = 1'b0;
            e_fd      = 1'b0;
            e_addr    = '0;
            e_data    = '0;
        end else begin
            model_step();
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("chipselect", 64'(chipselect), 64'(e_wr));
            check("write", 64'(write), 64'(e_wr));
            check("address", 64'(address), 64'(e_addr));
            check("writedata", 64'(writedata), 64'(e_data));
            check("frame_done", 64'(frame_done), 64'(e_fd));
            check("pending", 64'(pending), 64'(mq.size()));
            check("req_ready", 64'(req_ready), 64'(mq.size() < DEPTH));
            if (write) begin
                wr_count++;
                addr_log.push_back(address);
            end
            if (frame_done) fd_count++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [8:0] a, input logic [31:0] d);
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (req_ready) begin
                @(posedge clk);
                #2;
                req_valid = 1'b0;
                return;
            end
        end
        checks++;
        failures++;
        $display("FAIL push_timeout: got no req_ready expected acceptance at %0t", $time);
        req_valid = 1'b0;
    endtask

    task automatic frame(input int low);
        vga_vs_n = 1'b0;
        tick(low);
        vga_vs_n = 1'b1;
        tick(3);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1);
    end

    initial begin
        int wr0, fd0;
        bit acc;
        reset = 1'b1;
        tick(2);
        check("rst_chipselect", 64'(chipselect), 64'd0);
        check("rst_write", 64'(write), 64'd0);
        check("rst_address", 64'(address), 64'd0);
        check("rst_writedata", 64'(writedata), 64'd0);
        check("rst_pending", 64'(pending), 64'd0);
        check("rst_frame_done", 64'(frame_done), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd1);
        reset = 1'b0;
        cmp_en = 1'b1;
        tick(2);

        // Three queued updates, then one window.
        push(DINO_X, 32'd50); push(DINO_Y, 32'd120); push(SCORE, 32'd7);
        tick(3);
        check("idle_no_writes", 64'(wr_count), 64'd0);
        fd0 = fd_count;
        vga_vs_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("w0_write", 64'(write), 64'd1);
        check("w0_addr", 64'(address), 64'd0);
        check("w0_data", 64'(writedata), 64'd50);
        @(negedge clk);
        check("w1_addr", 64'(address), 64'd1);
        check("w1_data", 64'(writedata), 64'd120);
        @(negedge clk);
        check("w2_addr", 64'(address), 64'd10);
        check("w2_data", 64'(writedata), 64'd7);
        @(negedge clk);
        check("w3_write", 64'(write), 64'd0);
        check("fd_pulse", 64'(frame_done), 64'd1);
        @(negedge clk);
        check("fd_low", 64'(frame_done), 64'd0);
        push(SCORE_X, 32'd77);
        tick(4);
        check("wait_end_holds", 64'(wr_count), 64'd3);
        check("wait_end_fd_once", 64'(fd_count - fd0), 64'd1);
        vga_vs_n = 1'b1;
        tick(3);
        frame(8);
        check("next_frame_addr", 64'(addr_log[addr_log.size() - 1]), 64'd11);

        // Fill to full and hold a 17th request across the first pop.
        wr0 = wr_count;
        for (int i = 0; i < 16; i++) push(9'(i), 32'(1000 + i));
        check("full_pending", 64'(pending), 64'd16);
        check("full_ready", 64'(req_ready), 64'd0);
        fork
            push(9'd5, 32'd999);
            begin tick(3); vga_vs_n = 1'b0; end
        join
        tick(6);
        vga_vs_n = 1'b1;
        tick(3);
        repeat (4) frame(8);
        check("full_all_written", 64'(wr_count - wr0), 64'd17);
        check("full_drained", 64'(pending), 64'd0);

        // Burst limit: ten entries across three windows.
        wr0 = wr_count;
        for (int i = 0; i < 10; i++) push(9'(i + 1), 32'(i * 3));
        frame(10);
        check("burst1_pending", 64'(pending), 64'd6);
        check("burst1_writes", 64'(wr_count - wr0), 64'd4);
        frame(10);
        check("burst2_pending", 64'(pending), 64'd2);
        frame(10);

        // Continuous pushing while draining.
        for (int i = 0; i < 3; i++) push(9'(i + 30), 32'(i));
        fork
            for (int i = 0; i < 8; i++) push(9'(i + 40), 32'(i + 500));
            begin vga_vs_n = 1'b0; tick(12); vga_vs_n = 1'b1; end
        join
        tick(3);
        repeat (3) frame(8);
        check("stream_drained", 64'(pending), 64'd0);

        // Window closes early after two of five writes.
        for (int i = 0; i < 5; i++) push(9'(i + 20), 32'(i + 70));
        wr0 = wr_count;
        fd0 = fd_count;
        vga_vs_n = 1'b0;
        tick(2);
        vga_vs_n = 1'b1;
        tick(3);
        check("early_pending", 64'(pending), 64'd3);
        check("early_writes", 64'(wr_count - wr0), 64'd2);
        check("early_fd_once", 64'(fd_count - fd0), 64'd1);
        frame(8);
        check("early_rest_0", 64'(addr_log[addr_log.size() - 3]), 64'd22);
        check("early_rest_2", 64'(addr_log[addr_log.size() - 1]), 64'd24);

        // Reset in the middle of the second write.
        for (int i = 0; i < 5; i++) push(9'(i + 60), 32'(i + 90));
        wr0 = wr_count;
        vga_vs_n = 1'b0;
        tick(1);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("mid_rst_write", 64'(write), 64'd0);
        check("mid_rst_chipselect", 64'(chipselect), 64'd0);
        check("mid_rst_address", 64'(address), 64'd0);
        check("mid_rst_pending", 64'(pending), 64'd0);
        vga_vs_n = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(2);
        push(SCORE_Y, 32'd5); push(BIRD_X, 32'd6);
        tick(5);
        check("post_rst_no_write", 64'(wr_count - wr0), 64'd1);
        frame(8);
        check("post_rst_writes", 64'(wr_count - wr0), 64'd3);

        // Randomized traffic and vsync timing.
        fork
            for (int c = 0; c < 600; c++) begin
                @(negedge clk);
                acc = req_valid && req_ready;
                @(posedge clk);
                #2;
                if (!req_valid || acc) begin
                    req_valid = ($urandom_range(0, 2) != 0);
                    req_addr  = 9'($urandom_range(0, 12));
                    req_data  = $urandom;
                end
            end
            for (int t = 0; t < 60; t++) begin
                vga_vs_n = ~vga_vs_n;
                tick($urandom_range(1, 10));
            end
        join
        req_valid = 1'b0;
        vga_vs_n = 1'b1;
        tick(3);
        repeat (5) frame(10);
        check("final_drained", 64'(pending), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_reg_writer.md
VGA_REG_WRITER -- requirements
Module: vga_reg_writer

Interface
REQ-001 SHALL have parameter DEPTH, default 16: FIFO entries; power of two, minimum 2.
REQ-002 SHALL have parameter MAX_BURST, default 32: maximum bus writes per vertical-sync window.
REQ-003 SHALL have port clk, input, 1: single clock, same 50 MHz clock as the display block.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high.
REQ-005 SHALL have port req_valid, input, 1: producer offers an update.
REQ-006 SHALL have port req_ready, output, 1: FIFO can accept the update.
REQ-007 SHALL have port req_addr, input, 9: target register address.
REQ-008 SHALL have port req_data, input, 32: target register data.
REQ-009 SHALL have port vga_vs_n, input, 1: display VGA_VS, active-low vertical sync.
REQ-010 SHALL have port chipselect, output, 1: bus select toward the display register slave.
REQ-011 SHALL have port write, output, 1: bus write strobe.
REQ-012 SHALL have port address, output, 9: bus address.
REQ-013 SHALL have port writedata, output, 32: bus data.
REQ-014 SHALL have port pending, output, $clog2(DEPTH)+1: current FIFO occupancy.
REQ-015 SHALL have port frame_done, output, 1: one-cycle pulse when a drain window closes.

Function
REQ-016 SHALL accept an entry when req_valid && req_ready on a clock edge. req_ready = (pending < DEPTH), combinational from the count.
REQ-017 SHALL hold a stalled request. The producer keeps it stable and no entry is dropped or duplicated.
REQ-018 SHALL register vga_vs_n into vs_q. vs_start = vs_q && !vga_vs_n. vs_end = !vs_q && vga_vs_n.
REQ-019 SHALL implement FSM IDLE, DRAIN, WAIT_END.
- IDLE -> DRAIN on vs_start.
- DRAIN -> WAIT_END when the FIFO is empty, or when burst_cnt == MAX_BURST, while vga_vs_n is still low.
- DRAIN -> IDLE on vs_end.
- WAIT_END -> IDLE on vs_end.
REQ-020 SHALL pop one entry per cycle while in DRAIN with the FIFO non-empty, burst_cnt < MAX_BURST, and vga_vs_n low.
- On a pop, register chipselect=write=1 with the popped address and data for exactly one cycle.
- On a pop, increment burst_cnt.
REQ-021 SHALL place the first write on the outputs in the cycle after the edge where vs_start is true, giving one cycle of latency.
REQ-022 SHALL drive chipselect=write=0 whenever no pop occurred on the previous edge. address and writedata hold their last value.
REQ-023 SHALL clear burst_cnt on entry to DRAIN. burst_cnt saturates and never wraps.
REQ-024 SHALL pulse frame_done for exactly one cycle on every transition out of DRAIN.
REQ-025 SHALL leave pending unchanged on a simultaneous push and pop.
- A push into a full FIFO on the same edge as a pop is legal, since req_ready is 0 and no push occurs.
REQ-026 SHALL keep entries left unwritten when vs_end arrives in order for the next frame.
REQ-027 SHALL issue writes in strict FIFO order and never reorder or merge same-address entries.
REQ-028 SHALL issue no writes outside the vertical sync window (vga_vs_n high).
REQ-029 SHALL ignore a vs_start seen in DRAIN or WAIT_END.

Reset
REQ-030 SHALL, on reset assertion, immediately and asynchronously force all of the following:
- state=IDLE
- FIFO empty, pending=0
- burst_cnt=0, vs_q=1
- chipselect=0, write=0, address=0, writedata=0, frame_done=0
REQ-031 SHALL discard all queued entries on reset mid-drain. The first write after reset needs a fresh vs_start.

Structure
REQ-032 SHALL take ADDR_W=9, DATA_W=32 and display register address constants from shared package vga_reg_pkg. Constants: DINO_X=0 … GODZILLA_Y=9, SCORE=10, SCORE_X=11, SCORE_Y=12.
REQ-033 SHALL place the FSM state enum in vga_reg_pkg.
REQ-034 SHALL implement storage as one sub-module sync_fifo. Ports: push, pop, din, dout, count, full, empty. Read is first-word-fall-through.

Verification
REQ-035 Push (0,50),(1,120),(10,7) while vga_vs_n=1 -> no writes. Drop vga_vs_n -> writes addr 0/1/10, data 50/120/7, on 3 consecutive cycles starting 1 cycle after the edge. Then frame_done pulses and WAIT_END holds until vga_vs_n rises.
REQ-036 Push 16 entries with DEPTH=16 -> req_ready=0 and pending=16. Hold a 17th request -> accepted only after the first drain pop, with no loss.
REQ-037 MAX_BURST=4, 10 entries queued -> exactly 4 writes in frame 1, then pending=6. Next vsync -> 4 more writes, then pending=2.
REQ-038 Push continuously during DRAIN -> pending constant across simultaneous push/pop cycles, and output order equals input order.
REQ-039 Assert reset during the 2nd write of a 5-entry drain -> outputs are 0 in the same cycle and pending=0. After release, no writes until the next vga_vs_n falling edge.
REQ-040 Raise vga_vs_n after 2 of 5 writes -> state=IDLE, frame_done pulses once, and the remaining 3 are written first in the next window.
